rom_image_loader: RTL and testbench



---
 rtl/rom_loader_pkg.sv | 61 ++++++
 rtl/rom_image_loader_page_map.sv | 28 ++
 rtl/rom_image_loader.sv | 204 ++++++++++++++++++++
 tb/tb_rom_image_loader.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_loader_pkg.sv
// Shared types and helpers for the ROM image loader: FSM state enum and
// the file-extension decoder that maps a two-character extension to a page.
package rom_loader_pkg;

  // 16 KB segments.
  localparam int unsigned SEG_BITS = 14;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StWrite
  } ldr_state_e;

  typedef enum logic [1:0] {
    ExtHex,
    ExtZero,
    ExtMalformed
  } ext_kind_e;

  localparam ext_kind_e FILE_EXT_MALFORMED = ExtMalformed;

  typedef struct packed {
    ext_kind_e  kind;
    logic       combo;
    logic [7:0] hex;
  } ext_dec_t;

  // Bit 4 flags an uppercase hex digit, bits 3:0 carry its value.
  function automatic logic [4:0] hex_char(input logic [7:0] c);
    logic [4:0] r;
    r = 5'h00;
    if (c >= 8'h30 && c <= 8'h39) begin
      r = {1'b1, c[3:0]};
    end else if (c >= 8'h41 && c <= 8'h46) begin
      r = {1'b1, c[3:0] + 4'd9};
    end
    return r;
  endfunction

  // ext[15:8] is the first character, ext[7:0] the second.
  function automatic ext_dec_t ext_decode(input logic [15:0] ext);
    ext_dec_t   d;
    logic [4:0] hi;
    logic [4:0] lo;
    hi      = hex_char(ext[15:8]);
    lo      = hex_char(ext[7:0]);
    d.kind  = FILE_EXT_MALFORMED;
    d.combo = 1'b0;
    d.hex   = {hi[3:0], lo[3:0]};
    if (hi[4] && lo[4]) begin
      d.kind = ExtHex;
    end else if (ext == 16'h5A5A) begin      // "ZZ"
      d.kind = ExtZero;
    end else if (ext == 16'h5A30) begin      // "Z0"
      d.kind  = ExtZero;
      d.combo = 1'b1;
    end
    return d;
  endfunction

endpackage

// File: rtl/rom_image_loader_page_map.sv
// Populated-expansion-page bitmap: synchronous set and reset, combinational read.
module rom_page_map
  import rom_loader_pkg::*;
#(
  parameter int unsigned IDX_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             set_i,
  input  logic [IDX_W-1:0] set_idx_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             hit_o
);

  logic [(1 << IDX_W)-1:0] map_q;

  // Bits are only ever set; the whole map clears on system reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      map_q <= '0;
    end else if (set_i) begin
      map_q[set_idx_i] <= 1'b1;
    end
  end

  assign hit_o = map_q[rd_idx_i];

endmodule

// File: rtl/rom_image_loader.sv
// ROM image loader: streams HPS ioctl bytes into SDRAM, one ce_ref-long write
// per target bank, holding ioctl_wait for the whole byte.
// Optional feature macro: ROMLDR_CSUM_EN (running byte checksum on csum).
module rom_image_loader
  import rom_loader_pkg::*;
#(
  parameter int unsigned ADDR_W            = 23,
  parameter int unsigned BANKS             = 2,
  parameter int unsigned SYS_SEGS          = 8,
  parameter int unsigned SYS_SEGS_PER_BANK = 4,
  localparam int unsigned PAGE_W           = ADDR_W - SEG_BITS,
  localparam int unsigned BANK_W           = (BANKS > 1) ? $clog2(BANKS) : 1,
  parameter logic [SYS_SEGS_PER_BANK*PAGE_W-1:0] SYS_PAGE_MAP =
      {9'h1ff, 9'h107, 9'h100, 9'h000},
  parameter logic [PAGE_W-1:0] BAD_PAGE    = 9'h1EE,
  parameter logic [PAGE_W-1:0] COMBO_PAGE  = 9'h1FF
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ce_ref,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [7:0]        ioctl_index,
  input  logic [31:0]       ioctl_file_ext,
  output logic              ioctl_wait,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BANK_W-1:0] mem_bank,
  output logic [7:0]        mem_dout,
  output logic              busy,
  input  logic [PAGE_W-2:0] map_page,
  output logic              map_hit,
  output logic [7:0]        csum
);

  localparam int unsigned LOW_W     = PAGE_W - 1;
  localparam int unsigned SYS_IDX_W = (SYS_SEGS_PER_BANK > 1) ? $clog2(SYS_SEGS_PER_BANK) : 1;

  ldr_state_e        state_q;
  logic              dl_q;
  logic              wait_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BANK_W-1:0] bank_q;
  logic [BANK_W-1:0] last_bank_q;
  logic [7:0]        data_q;
  logic [PAGE_W-1:0] page_q;
  logic              combo_q;
  logic              exp_q;

  logic              dl_start;
  ext_dec_t          dec;
  logic [PAGE_W-1:0] start_page;
  logic              is_exp;
  logic [31:0]       seg_w;
  logic              sys_ok;
  logic [PAGE_W-1:0] sys_page;
  logic [BANK_W-1:0] sys_bank;
  logic [LOW_W-1:0]  exp_low;
  logic [ADDR_W-1:0] exp_addr;
  logic [ADDR_W-1:0] sys_addr;
  logic              rep;
  logic [BANK_W-1:0] single_bank;
  logic              byte_done;
  logic              map_set;
  logic              unused_ext;

  logic [PAGE_W-1:0] sys_map [SYS_SEGS_PER_BANK];
  for (genvar g = 0; g < SYS_SEGS_PER_BANK; g++) begin : g_sys_map
    assign sys_map[g] = SYS_PAGE_MAP[g*PAGE_W +: PAGE_W];
  end

  assign unused_ext = ^ioctl_file_ext[31:16];
  assign dl_start   = ioctl_download & ~dl_q;
  assign dec        = ext_decode(ioctl_file_ext[15:0]);
  assign is_exp     = (ioctl_index != 8'd0);

  // System image: segment picks page via the map and bank by segment group.
  assign seg_w    = 32'(ioctl_addr[24:14]);
  assign sys_ok   = (seg_w < SYS_SEGS);
  assign sys_page = sys_map[SYS_IDX_W'(seg_w % SYS_SEGS_PER_BANK)];
  assign sys_bank = BANK_W'(seg_w / SYS_SEGS_PER_BANK);
  assign sys_addr = {sys_page, ioctl_addr[SEG_BITS-1:0]};

  // Expansion image: page offset wraps inside the low bits, MSB is kept.
  assign exp_low     = page_q[LOW_W-1:0] + LOW_W'(ioctl_addr[21:14]);
  assign exp_addr    = {page_q[PAGE_W-1], exp_low, ioctl_addr[SEG_BITS-1:0]};
  assign rep         = (|ioctl_index[5:0]) | (ioctl_index[7:6] == 2'b01);
  assign single_bank = BANK_W'(ioctl_index[7] & ioctl_index[6]);

  // Page selected by the file extension at download start.
  always_comb begin
    start_page = BAD_PAGE;
    case (dec.kind)
      ExtHex:  start_page = {1'b1, LOW_W'(dec.hex)};
      ExtZero: start_page = '0;
      default: start_page = BAD_PAGE;
    endcase
  end

  assign byte_done = (state_q == StWrite) & ce_ref & (bank_q == last_bank_q);
  assign map_set   = byte_done & exp_q & page_q[PAGE_W-1];

  // Loader FSM: latch byte in IDLE, one ARM/WRITE pair per target bank.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= StIdle;
      dl_q        <= 1'b0;
      wait_q      <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      bank_q      <= '0;
      last_bank_q <= '0;
      data_q      <= 8'h00;
      page_q      <= '0;
      combo_q     <= 1'b0;
      exp_q       <= 1'b0;
    end else begin
      dl_q <= ioctl_download;
      if (dl_start) begin
        combo_q <= 1'b0;
        if (is_exp) begin
          page_q  <= start_page;
          combo_q <= dec.combo;
        end
      end
      unique case (state_q)
        StIdle: begin
          if (ioctl_wr && ioctl_download && (is_exp || sys_ok)) begin
            addr_q      <= is_exp ? exp_addr : sys_addr;
            bank_q      <= is_exp ? (rep ? '0 : single_bank) : sys_bank;
            last_bank_q <= is_exp ? (rep ? BANK_W'(BANKS - 1) : single_bank) : sys_bank;
            data_q      <= ioctl_dout;
            exp_q       <= is_exp;
            wait_q      <= 1'b1;
            state_q     <= StArm;
          end
        end
        StArm: begin
          if (ce_ref) begin
            wr_q    <= 1'b1;
            state_q <= StWrite;
          end
        end
        StWrite: begin
          if (ce_ref) begin
            wr_q <= 1'b0;
            if (bank_q != last_bank_q) begin
              bank_q  <= bank_q + 1'b1;
              state_q <= StArm;
            end else begin
              wait_q  <= 1'b0;
              state_q <= StIdle;
              // Combo image: after the first 16 KB switch to the combo page.
              if (exp_q && combo_q && (addr_q[SEG_BITS-1:0] == '1)) begin
                page_q  <= COMBO_PAGE;
                combo_q <= 1'b0;
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  rom_page_map #(
    .IDX_W (PAGE_W - 1)
  ) u_page_map (
    .clk_i     (clk_sys),
    .rst_i     (reset),
    .set_i     (map_set),
    .set_idx_i (page_q[PAGE_W-2:0]),
    .rd_idx_i  (map_page),
    .hit_o     (map_hit)
  );

`ifdef ROMLDR_CSUM_EN
  logic [7:0] csum_q;

  // Each byte counted once, on the cycle its final bank write retires.
  always_ff @(posedge clk_sys) begin
    if (reset || dl_start) begin
      csum_q <= 8'h00;
    end else if (byte_done) begin
      csum_q <= csum_q + data_q;
    end
  end

  assign csum = csum_q;
`else
  assign csum = 8'h00;
`endif

  assign ioctl_wait = wait_q;
  assign mem_wr     = wr_q;
  assign mem_addr   = addr_q;
  assign mem_bank   = bank_q;
  assign mem_dout   = data_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_rom_image_loader.sv
// Randomised scoreboard bench for rom_image_loader: a behavioural model
// predicts SDRAM writes, a monitor pops and compares each mem_wr pulse.
module tb_rom_image_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce_ref = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [7:0]  ioctl_index = '0;
  logic [31:0] ioctl_file_ext = '0;
  logic        ioctl_wait;
  logic        mem_wr;
  logic [22:0] mem_addr;
  logic [0:0]  mem_bank;
  logic [7:0]  mem_dout;
  logic        busy;
  logic [7:0]  map_page = '0;
  logic        map_hit;
  logic [7:0]  csum;

  always #5 clk = ~clk;

  rom_image_loader dut (
    .clk_sys        (clk),
    .reset          (reset),
    .ce_ref         (ce_ref),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .ioctl_file_ext (ioctl_file_ext),
    .ioctl_wait     (ioctl_wait),
    .mem_wr         (mem_wr),
    .mem_addr       (mem_addr),
    .mem_bank       (mem_bank),
    .mem_dout       (mem_dout),
    .busy           (busy),
    .map_page       (map_page),
    .map_hit        (map_hit),
    .csum           (csum)
  );

  typedef struct {
    int unsigned addr;
    int unsigned bank;
    int unsigned data;
  } wr_t;

  wr_t  exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state
  int   m_page = 0;
  bit   m_combo = 1'b0;
  bit   m_map[256];
  int   m_csum = 0;
  int   sys_map[4] = '{'h000, 'h100, 'h107, 'h1ff};
  logic [7:0] cur_idx = '0;
  string hx = "0123456789ABCDEF";

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int hexval(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    return -1;
  endfunction

  function automatic void push(input int a, input int b, input int d);
    wr_t w;
    w.addr = a;
    w.bank = b;
    w.data = d;
    exp_q.push_back(w);
  endfunction

  function automatic int exp_csum();
`ifdef ROMLDR_CSUM_EN
    return m_csum;
`else
    return 0;
`endif
  endfunction

  task automatic model_start(input logic [7:0] idx, input logic [15:0] ext);
    int h;
    int l;
    m_combo = 1'b0;
    m_csum  = 0;
    if (idx != 8'd0) begin
      h = hexval(ext[15:8]);
      l = hexval(ext[7:0]);
      if (h >= 0 && l >= 0) m_page = 256 + h * 16 + l;
      else if (ext == "ZZ") m_page = 0;
      else if (ext == "Z0") begin
        m_page  = 0;
        m_combo = 1'b1;
      end else m_page = 'h1EE;
    end
  endtask

  task automatic model_byte(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d,
                            output bit acc);
    int off;
    int seg;
    int pg;
    off = int'(a) % 16384;
    seg = int'(a) / 16384;
    acc = 1'b1;
    if (idx == 8'd0) begin
      if (seg >= 8) begin
        acc = 1'b0;
        return;
      end
      push(sys_map[seg % 4] * 16384 + off, seg / 4, int'(d));
    end else begin
      pg = (m_page >= 256 ? 256 : 0) + ((m_page % 256) + (seg % 256)) % 256;
      if ((idx % 64) != 0 || (idx / 64) == 1) begin
        push(pg * 16384 + off, 0, int'(d));
        push(pg * 16384 + off, 1, int'(d));
      end else begin
        push(pg * 16384 + off, (idx / 64 == 3) ? 1 : 0, int'(d));
      end
      if (m_page >= 256) m_map[m_page - 256] = 1'b1;
      if (m_combo && off == 16383) begin
        m_page  = 'h1FF;
        m_combo = 1'b0;
      end
    end
    m_csum = (m_csum + int'(d)) % 256;
  endtask

  task automatic start_download(input logic [7:0] idx, input logic [15:0] ext);
    @(negedge clk);
    ioctl_download = 1'b0;
    @(negedge clk);
    ioctl_index    = idx;
    ioctl_file_ext = {16'h0000, ext};
    ioctl_download = 1'b1;
    cur_idx        = idx;
    model_start(idx, ext);
    repeat (2) @(negedge clk);
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    bit acc;
    int n;
    @(negedge clk);
    model_byte(cur_idx, a, d, acc);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    @(negedge clk);
    ioctl_wr = 1'b0;
    check("wait_rise", ioctl_wait, 32'(acc));
    if (acc) begin
      n = 0;
      while (ioctl_wait && n < 400) begin
        @(negedge clk);
        n++;
      end
      check("wait_fall_in_time", ioctl_wait, 0);
      check("busy_after_byte", busy, 0);
      check("csum", csum, exp_csum());
    end else begin
      check("busy_dropped_byte", busy, 0);
    end
  endtask

  // ce_ref: one cycle in every 16
  initial begin
    forever begin
      repeat (15) @(negedge clk);
      ce_ref = 1'b1;
      @(negedge clk);
      ce_ref = 1'b0;
    end
  end

  // Monitor: pop one expected write per rising mem_wr, check pulse length and stability
  initial begin
    bit  prev;
    bit  stable;
    int  len;
    wr_t cur;
    wr_t e;
    prev   = 1'b0;
    stable = 1'b1;
    len    = 0;
    forever begin
      @(negedge clk);
      if (mem_wr && !prev) begin
        len       = 1;
        stable    = 1'b1;
        cur.addr  = 32'(mem_addr);
        cur.bank  = 32'(mem_bank);
        cur.data  = 32'(mem_dout);
        check("write_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("mem_addr", 32'(mem_addr), e.addr);
          check("mem_bank", 32'(mem_bank), e.bank);
          check("mem_dout", 32'(mem_dout), e.data);
        end
      end else if (mem_wr) begin
        len++;
        if (32'(mem_addr) != cur.addr || 32'(mem_bank) != cur.bank || 32'(mem_dout) != cur.data)
          stable = 1'b0;
      end else if (prev) begin
        check("wr_len", 32'(len), 16);
        check("wr_stable", 32'(stable), 1);
      end
      prev = mem_wr;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ext;
    logic [7:0]  idx;
    int          seg;
    logic [7:0]  csum_req;

    for (int i = 0; i < 256; i++) m_map[i] = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_wait", ioctl_wait, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_bank", 32'(mem_bank), 0);
    check("rst_dout", mem_dout, 0);
    check("rst_csum", csum, 0);
    for (int p = 0; p < 256; p += 51) begin
      map_page = 8'(p);
      #1;
      check("rst_map", map_hit, 0);
    end

    // System image: directed segments then random ones
    start_download(8'h00, "ZZ");
    send_byte({11'd2, 14'h0010}, 8'h5A);
    check("sys_seg2_addr", 32'(mem_addr), 32'h41C010);
    check("sys_seg2_bank", 32'(mem_bank), 0);
    send_byte({11'd6, 14'h0010}, 8'hA5);
    check("sys_seg6_addr", 32'(mem_addr), 32'h41C010);
    check("sys_seg6_bank", 32'(mem_bank), 1);
    send_byte({11'd8, 14'h0123}, 8'h77);
    for (int i = 0; i < 10; i++) begin
      seg = $urandom_range(0, 9);
      repeat ($urandom_range(0, 20)) @(negedge clk);
      send_byte({11'(seg), 14'($urandom)}, 8'($urandom));
    end

    // Expansion "07", replicated to both banks
    start_download(8'h01, "07");
    send_byte(25'h0, 8'h3C);
    check("ext07_addr", 32'(mem_addr), 32'h41C000);
    map_page = 8'h07;
    #1;
    check("ext07_map", map_hit, 1);

    // Combo image into single bank 0
    start_download(8'h80, "Z0");
    send_byte(25'h3FFE, 8'h11);
    send_byte(25'h3FFF, 8'h22);
    check("combo_first_addr", 32'(mem_addr), 32'h003FFF);
    send_byte(25'h4000, 8'h33);
    check("combo_switch_addr", 32'(mem_addr), 32'h400000);
    send_byte(25'h4001, 8'h44);
    map_page = 8'hFF;
    #1;
    check("combo_map_ff", map_hit, 1);

    // Malformed extension, single bank 1
    start_download(8'hC0, "g1");
    send_byte(25'h0100, 8'h99);
    check("bad_ext_addr", 32'(mem_addr), 32'h7B8100);
    check("bad_ext_bank", 32'(mem_bank), 1);

    // Checksum counts each byte once despite replication
    start_download(8'h01, "10");
    send_byte(25'h0000, 8'hFF);
    send_byte(25'h0001, 8'h02);
`ifdef ROMLDR_CSUM_EN
    csum_req = 8'h01;
`else
    csum_req = 8'h00;
`endif
    check("csum_ff_02", csum, 32'(csum_req));

    // Random downloads
    for (int dl = 0; dl < 8; dl++) begin
      case ($urandom_range(0, 4))
        0: idx = 8'h01;
        1: idx = 8'h40;
        2: idx = 8'h80;
        3: idx = 8'hC0;
        default: idx = 8'($urandom_range(0, 255));
      endcase
      case ($urandom_range(0, 3))
        0: ext = {hx[$urandom_range(0, 15)], hx[$urandom_range(0, 15)]};
        1: ext = "ZZ";
        2: ext = "Z0";
        default: ext = 16'($urandom);
      endcase
      start_download(idx, ext);
      for (int b = 0; b < 6; b++) begin
        repeat ($urandom_range(0, 20)) @(negedge clk);
        if (idx == 8'd0) send_byte({11'($urandom_range(0, 9)), 14'($urandom)}, 8'($urandom));
        else send_byte(25'($urandom), 8'($urandom));
      end
    end

    // Reset 3 cycles into ARM: no write may ever appear for this byte
    start_download(8'h01, "2A");
    do @(posedge clk); while (!ce_ref);
    @(negedge clk);
    ioctl_addr = 25'h0042;
    ioctl_dout = 8'h5A;
    ioctl_wr   = 1'b1;
    @(negedge clk);
    ioctl_wr = 1'b0;
    check("armrst_wait_up", ioctl_wait, 1);
    repeat (2) @(negedge clk);
    reset          = 1'b1;
    ioctl_download = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("armrst_mem_wr", mem_wr, 0);
    check("armrst_wait", ioctl_wait, 0);
    check("armrst_busy", busy, 0);
    check("armrst_csum", csum, 0);
    map_page = 8'h07;
    #1;
    check("armrst_map07", map_hit, 0);
    for (int i = 0; i < 256; i++) m_map[i] = 1'b0;
    m_csum  = 0;
    m_combo = 1'b0;
    m_page  = 0;
    repeat (40) @(negedge clk);

    // One more download after reset, then sweep the whole bitmap
    start_download(8'h40, "3C");
    send_byte(25'h0000, 8'h12);
    send_byte(25'h1_C000, 8'h34);
    @(negedge clk);
    for (int p = 0; p < 256; p++) begin
      map_page = 8'(p);
      #1;
      check("map_sweep", map_hit, 32'(m_map[p]));
    end

    repeat (40) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
